// File: rtl/pipeline_hazard_controller.sv
// ============================================================================
// pipeline_hazard_controller : stall/flush sequencer and halt drain for the
// 5-stage in-order core.                                     Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_controller #(
   parameter int DRAIN_CYCLES = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic                 if_miss,
   input  logic                 ma_busy,
   input  logic [4:0]           id_rs1_addr,
   input  logic [4:0]           id_rs2_addr,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic                 ex_is_load,
   input  logic [4:0]           ex_rd_addr,
   input  logic                 ex_rd_write,
   input  logic                 ex_mispredict,
   input  logic                 ex_is_halt,
   output logic                 stall_if,
   output logic                 stall_id,
   output logic                 stall_ex,
   output logic                 stall_ma,
   output logic                 flush_id,
   output logic                 flush_ex,
   output logic                 flush_ma,
   output logic                 flush_wb,
   output logic                 redirect,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] stall_cycles
);

   localparam int            DW         = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_CYCLES);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [DW-1:0]         drain_q, drain_d;
   logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
   logic [DW-1:0]         w_drain_inc;
   logic                  w_lu;

   // x0 is hardwired zero, so a load targeting it never produces a hazard.
   assign w_lu = ex_is_load & ex_rd_write & (ex_rd_addr != 5'd0) &
                 ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr)) |
                  (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

   assign w_drain_inc  = drain_q + DW'(1);
   assign stall_cycles = stall_cnt_q;

   always_comb begin
      state_d  = state_q;
      drain_d  = drain_q;
      stall_if = 1'b0;
      stall_id = 1'b0;
      stall_ex = 1'b0;
      stall_ma = 1'b0;
      flush_id = 1'b0;
      flush_ex = 1'b0;
      flush_ma = 1'b0;
      flush_wb = 1'b0;
      redirect = 1'b0;
      halted   = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (ma_busy) begin
               {stall_if, stall_id, stall_ex, stall_ma} = 4'b1111;
               flush_wb = 1'b1;
            end else if (ex_mispredict) begin
               redirect = 1'b1;
               flush_id = 1'b1;
               flush_ex = 1'b1;
            end else if (ex_is_halt) begin
               state_d  = ST_DRAIN;
               drain_d  = '0;
               stall_if = 1'b1;
               flush_id = 1'b1;
               flush_ex = 1'b1;
            end else if (w_lu) begin
               // ID keeps its instruction even if fetch also missed.
               stall_if = 1'b1;
               stall_id = 1'b1;
               flush_ex = 1'b1;
            end else if (if_miss) begin
               stall_if = 1'b1;
               flush_id = 1'b1;
            end
         end

         ST_DRAIN: begin
            if (ma_busy) begin
               {stall_if, stall_id, stall_ex, stall_ma} = 4'b1111;
               flush_wb = 1'b1;
            end else begin
               stall_if = 1'b1;
               flush_id = 1'b1;
               flush_ex = 1'b1;
               drain_d  = w_drain_inc;
               if (w_drain_inc == C_DRAIN_LAST) begin
                  state_d = ST_HALTED;
               end
            end
         end

         ST_HALTED: begin
            {stall_if, stall_id, stall_ex, stall_ma} = 4'b1111;
            halted = 1'b1;
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Reset forces every pipe register to a bubble regardless of state.
      if (!rstN) begin
         {stall_if, stall_id, stall_ex, stall_ma} = 4'b0000;
         {flush_id, flush_ex, flush_ma, flush_wb} = 4'b1111;
         redirect = 1'b0;
         halted   = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((state_q == ST_RUN) && stall_if && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q     <= ST_RUN;
         drain_q     <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         drain_q     <= drain_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
// ============================================================================
// tb_pipeline_hazard_controller : scoreboard bench with a behavioural model of
// the hazard priority rules and halt drain.                  Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_controller;

   localparam int DRAIN = 2;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   logic          rstN, if_miss, ma_busy, id_uses_rs1, id_uses_rs2;
   logic [4:0]    id_rs1_addr, id_rs2_addr, ex_rd_addr;
   logic          ex_is_load, ex_rd_write, ex_mispredict, ex_is_halt;
   logic          stall_if, stall_id, stall_ex, stall_ma;
   logic          flush_id, flush_ex, flush_ma, flush_wb, redirect, halted;
   logic [CW-1:0] stall_cycles;

   typedef struct {
      logic [9:0]    outs;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t scb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   // Model state: 0 = running, 1 = draining, 2 = halted.
   int      m_mode = 0;
   int      m_left = 0;
   longint  m_cnt  = 0;
   localparam longint M_MAX = (64'd1 << CW) - 1;

   always #5 clk = ~clk;

   pipeline_hazard_controller #(.DRAIN_CYCLES(DRAIN), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rstN(rstN), .if_miss(if_miss), .ma_busy(ma_busy),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
      .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr), .ex_rd_write(ex_rd_write),
      .ex_mispredict(ex_mispredict), .ex_is_halt(ex_is_halt),
      .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_ma(stall_ma),
      .flush_id(flush_id), .flush_ex(flush_ex), .flush_ma(flush_ma), .flush_wb(flush_wb),
      .redirect(redirect), .halted(halted), .stall_cycles(stall_cycles)
   );

   // Drive one cycle of inputs, predict the response, advance the model.
   task automatic step(input logic r, input logic miss, input logic busy,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic ld,
                       input logic [4:0] rd, input logic rdw,
                       input logic mp, input logic hlt);
      exp_t   e;
      logic   hazard;
      rstN = r; if_miss = miss; ma_busy = busy;
      id_rs1_addr = rs1; id_rs2_addr = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      ex_is_load = ld; ex_rd_addr = rd; ex_rd_write = rdw;
      ex_mispredict = mp; ex_is_halt = hlt;

      hazard = ld && rdw && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      e.cnt  = CW'(m_cnt);
      if (!r) begin
         e.outs = 10'b0000_1111_0_0;
         m_mode = 0; m_left = 0; m_cnt = 0;
      end else if (m_mode == 0) begin
         if (busy)        e.outs = 10'b1111_0001_0_0;
         else if (mp)     e.outs = 10'b0000_1100_1_0;
         else if (hlt) begin
            e.outs = 10'b1000_1100_0_0;
            m_mode = 1; m_left = DRAIN;
         end
         else if (hazard) e.outs = 10'b1100_0100_0_0;
         else if (miss)   e.outs = 10'b1000_1000_0_0;
         else             e.outs = 10'b0;
         if (e.outs[9] && m_cnt < M_MAX) m_cnt++;
      end else if (m_mode == 1) begin
         if (busy) e.outs = 10'b1111_0001_0_0;
         else begin
            e.outs = 10'b1000_1100_0_0;
            m_left--;
            if (m_left == 0) m_mode = 2;
         end
      end else begin
         e.outs = 10'b1111_0000_0_1;
      end
      scb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin : monitor
      exp_t       e;
      logic [9:0] got;
      forever begin
         @(negedge clk);
         if (scb.size() > 0) begin
            e   = scb.pop_front();
            got = {stall_if, stall_id, stall_ex, stall_ma,
                   flush_id, flush_ex, flush_ma, flush_wb, redirect, halted};
            checks++;
            if (got !== e.outs) begin
               errors++;
               $display("FAIL outputs cyc=%0d got=%b exp=%b", cyc, got, e.outs);
            end
            checks++;
            if (stall_cycles !== e.cnt) begin
               errors++;
               $display("FAIL stall_cycles cyc=%0d got=%0d exp=%0d", cyc, stall_cycles, e.cnt);
            end
            cyc++;
         end
      end
   end

   initial begin : stimulus
      int wait_n;
      rstN = 0; if_miss = 0; ma_busy = 0; id_rs1_addr = 0; id_rs2_addr = 0;
      id_uses_rs1 = 0; id_uses_rs2 = 0; ex_is_load = 0; ex_rd_addr = 0;
      ex_rd_write = 0; ex_mispredict = 0; ex_is_halt = 0;
      @(posedge clk);
      #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 1, 3, 3, 1, 1, 1, 3, 1, 1, 1);
      idle();
      // Load-use then release.
      step(1, 0, 0, 5, 0, 1, 0, 1, 5, 1, 0, 0);
      step(1, 0, 0, 5, 0, 1, 0, 0, 5, 1, 0, 0);
      // Load to x0, rs2 match, unused operand match.
      step(1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0);
      step(1, 0, 0, 1, 7, 1, 1, 1, 7, 1, 0, 0);
      step(1, 0, 0, 7, 1, 0, 1, 1, 7, 1, 0, 0);
      step(1, 0, 0, 7, 7, 1, 1, 1, 7, 0, 0, 0);
      // Mispredict over load-use and fetch miss; load-use with fetch miss.
      step(1, 1, 0, 5, 0, 1, 0, 1, 5, 1, 1, 0);
      step(1, 1, 0, 5, 0, 1, 0, 1, 5, 1, 0, 0);
      step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // MA wait holding a mispredict for three cycles.
      for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      // Clean halt, then halt with MA waits during drain.
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 4; i++) idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // Saturate the stall counter with fetch misses.
      for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle();
      // Randomized traffic with small register range to provoke hazards.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) >= 2,
              $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), $urandom_range(0, 99) < 40,
              5'($urandom_range(0, 3)), $urandom_range(0, 99) < 80,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 3);
      end
      wait_n = 0;
      while (scb.size() > 0 && wait_n < 5) begin
         @(posedge clk);
         wait_n++;
      end
      checks++;
      if (scb.size() != 0) begin
         errors++;
         $display("FAIL drain_scoreboard left=%0d exp=0", scb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central stall/flush sequencer for the 5-stage in-order core (IF, ID, EX, MA, WB).
- Drives per-stage hold and bubble-insert controls for the Decode, Execute, MemoryAccess and WriteBack stage pipe registers.
- Resolves load-use hazards, branch/next-PC mispredicts, instruction-fetch misses and multi-cycle data-memory waits.
- Sequences the halt drain: RUN -> DRAIN -> HALTED, with a saturating stall-cycle counter for performance monitoring.

Parameters:
- DRAIN_CYCLES, 2, cycles after halt leaves EX before halted asserts (MA + WB).
- CNT_WIDTH, 32, width of stall_cycles counter.

Ports:
- clk  in  1  core clock.
- rstN  in  1  synchronous active-low reset.
- if_miss  in  1  fetch result not valid this cycle.
- ma_busy  in  1  data memory access in MA not complete.
- id_rs1_addr  in  5  rs1 of instruction in ID.
- id_rs2_addr  in  5  rs2 of instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_is_load  in  1  EX holds a load.
- ex_rd_addr  in  5  EX destination register.
- ex_rd_write  in  1  EX writes rd.
- ex_mispredict  in  1  EX branch outcome or next PC differs from prediction.
- ex_is_halt  in  1  EX holds halt.
- stall_if  out  1  hold PC.
- stall_id  out  1  hold Decode pipe reg.
- stall_ex  out  1  hold Execute pipe reg.
- stall_ma  out  1  hold MemoryAccess pipe reg.
- flush_id  out  1  load bubble into Decode pipe reg.
- flush_ex  out  1  load bubble into Execute pipe reg.
- flush_ma  out  1  load bubble into MemoryAccess pipe reg.
- flush_wb  out  1  load bubble into WriteBack pipe reg.
- redirect  out  1  PC takes corrected target from EX.
- halted  out  1  core halted.
- stall_cycles  out  CNT_WIDTH  count of cycles with stall_if=1, RUN state only.

Behaviour:
- Stall and flush outputs are combinational from inputs and registered state. FSM state, drain counter and stall_cycles are registered.
- Reset: while rstN=0 at a clk edge, state goes to RUN, drain counter to 0, and stall_cycles to 0.
- While rstN is low, outputs are: all stall_* = 0, all flush_* = 1, redirect = 0, halted = 0. Reset mid-DRAIN or in HALTED returns to RUN.
- Load-use hazard (lu): ex_is_load & ex_rd_write & ex_rd_addr!=0 & ((id_uses_rs1 & id_rs1_addr==ex_rd_addr) | (id_uses_rs2 & id_rs2_addr==ex_rd_addr)).
- Priority in RUN (highest first):
  1. ma_busy: stall_if, stall_id, stall_ex and stall_ma = 1; flush_wb = 1; all other flushes = 0; redirect = 0. A mispredict or halt in EX waits until ma_busy drops.
  2. ex_mispredict: redirect = 1; flush_id = 1; flush_ex = 1; no stalls. lu and if_miss are ignored because the ID instruction is wrong-path.
  3. ex_is_halt: next state is DRAIN; stall_if = 1; flush_id = 1; flush_ex = 1.
  4. lu: stall_if = 1; stall_id = 1; flush_ex = 1. Exactly 1 bubble per hazard.
  5. if_miss: stall_if = 1; flush_id = 1.
  6. Otherwise all outputs are 0.
- lu and if_miss together: lu outputs apply and flush_id = 0 (ID holds its instruction). The PC remains stalled.
- DRAIN:
  - stall_if = 1; flush_id = 1; flush_ex = 1.
  - ma_busy still freezes MA per rule 1, and the drain counter does not advance while ma_busy = 1.
  - The counter increments each non-busy cycle. On reaching DRAIN_CYCLES, next state is HALTED.
- HALTED: all stall_* = 1; all flush_* = 0; halted = 1; redirect = 0. Only reset exits.
- stall_cycles: increments when state==RUN and stall_if = 1. Saturates at all-ones with no wrap.
- Inputs X-free after reset. Register x0 never creates a hazard.

Test Plan:
- Load-use: EX lw rd=5, ID add rs1=5 -> 1 cycle with stall_if=1, stall_id=1, flush_ex=1; next cycle with ex_is_load=0 all 0; stall_cycles=1.
- x0 load: ex_rd_addr=0, id_rs1_addr=0, ex_is_load=1 -> no stall, all outputs 0.
- Mispredict with lu and if_miss all 1 -> redirect=1, flush_id=1, flush_ex=1, stall_if=0, stall_id=0.
- ma_busy held 3 cycles with ex_mispredict=1 -> 3 cycles of stalls plus flush_wb=1 and redirect=0; cycle 4 redirect=1.
- Halt: ex_is_halt=1 at cycle T -> DRAIN; halted=1 from cycle T+3 (DRAIN_CYCLES=2); with ma_busy=1 during DRAIN for 2 cycles, halted is delayed to T+5.
- Reset in HALTED: rstN=0 for 1 cycle -> halted=0, all flush_*=1 during reset; RUN with outputs 0 after; stall_cycles=0.
